// File: rtl/id_r_pipe.sv
// Decode/register-read stage for R-type instructions (SPECIAL/SPECIAL2) feeding EX.
// Resolves JR/JALR branch requests and tracks the branch delay slot.
module id_r_pipe #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] pc,
    input  logic [31:0]       inst,
    output logic              rd_en_1,
    output logic [REG_AW-1:0] rd_addr_1,
    output logic              rd_en_2,
    output logic [REG_AW-1:0] rd_addr_2,
    input  logic [DATA_W-1:0] rd_data_1,
    input  logic [DATA_W-1:0] rd_data_2,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] op1,
    output logic [DATA_W-1:0] op2,
    output logic [4:0]        shamt,
    output logic [5:0]        funct,
    output logic              wr_en,
    output logic [REG_AW-1:0] wr_addr,
    output logic              in_ds,
    output logic              br_flag,
    output logic [ADDR_W-1:0] br_addr,
    output logic              err_jump_in_ds
);

    typedef enum logic {NORM = 1'b0, DS = 1'b1} ds_state_t;

    ds_state_t state, state_nx;
    logic      ds_now;

    logic [5:0]        opcode_f;
    logic [5:0]        funct_f;
    logic [REG_AW-1:0] rs_f, rt_f, rd_f;
    logic              is_special, is_r, is_jr, is_jalr, is_jump;
    logic              accept;
    logic [ADDR_W-1:0] link_addr;

    logic              vld_p1;
    logic [DATA_W-1:0] op1_p1, op2_p1;
    logic [4:0]        shamt_p1;
    logic [5:0]        funct_p1;
    logic              wr_en_p1, in_ds_p1, br_flag_p1, err_p1;
    logic [REG_AW-1:0] wr_addr_p1;
    logic [ADDR_W-1:0] br_addr_p1;

    function automatic logic wr_allow(input logic r, input logic jr, input logic [5:0] fn,
                                      input logic special, input logic [REG_AW-1:0] rd,
                                      input logic [DATA_W-1:0] d2, input logic bad_jump);
        logic movz_kill, movn_kill;
        movz_kill = special && (fn == 6'h0A) && (d2 != '0);
        movn_kill = special && (fn == 6'h0B) && (d2 == '0);
        return r && !jr && (rd != '0) && !movz_kill && !movn_kill && !bad_jump;
    endfunction

    assign opcode_f   = inst[31:26];
    assign funct_f    = inst[5:0];
    assign rs_f       = REG_AW'(inst[25:21]);
    assign rt_f       = REG_AW'(inst[20:16]);
    assign rd_f       = REG_AW'(inst[15:11]);
    assign is_special = (opcode_f == 6'h00);
    assign is_r       = is_special || (opcode_f == 6'h1C);
    assign is_jr      = is_special && (funct_f == 6'h08);
    assign is_jalr    = is_special && (funct_f == 6'h09);
    assign is_jump    = is_jr || is_jalr;
    assign link_addr  = pc + ADDR_W'(8);

    assign in_ready  = !rst && (!vld_p1 || out_ready);
    assign accept    = in_valid && in_ready;
    assign rd_en_1   = !rst && in_valid && is_r;
    assign rd_en_2   = rd_en_1;
    assign rd_addr_1 = rd_en_1 ? rs_f : '0;
    assign rd_addr_2 = rd_en_2 ? rt_f : '0;

    // Delay-slot FSM: state register
    always_ff @(posedge clk) begin
        if (rst) state <= NORM;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (flush) begin
            state_nx = NORM;
        end else if (accept) begin
            case (state)
                NORM:    state_nx = is_jump ? DS : NORM;
                DS:      state_nx = NORM;
                default: state_nx = NORM;
            endcase
        end
    end

    always_comb begin
        ds_now = (state == DS);
    end

    // Stage p1: EX payload register
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1     <= 1'b0;
            op1_p1     <= '0;
            op2_p1     <= '0;
            shamt_p1   <= '0;
            funct_p1   <= '0;
            wr_en_p1   <= 1'b0;
            wr_addr_p1 <= '0;
            in_ds_p1   <= 1'b0;
            br_flag_p1 <= 1'b0;
            br_addr_p1 <= '0;
            err_p1     <= 1'b0;
        end else if (flush) begin
            vld_p1     <= 1'b0;
            br_flag_p1 <= 1'b0;
            err_p1     <= 1'b0;
        end else if (accept) begin
            vld_p1   <= 1'b1;
            shamt_p1 <= inst[10:6];
            funct_p1 <= funct_f;
            in_ds_p1 <= ds_now;
            if (!is_r)        op1_p1 <= '0;
            else if (is_jalr) op1_p1 <= DATA_W'(link_addr);
            else if (is_jr)   op1_p1 <= '0;
            else              op1_p1 <= rd_data_1;
            op2_p1 <= is_r ? rd_data_2 : '0;
            if (wr_allow(is_r, is_jr, funct_f, is_special, rd_f, rd_data_2, is_jump && ds_now)) begin
                wr_en_p1   <= 1'b1;
                wr_addr_p1 <= rd_f;
            end else begin
                wr_en_p1   <= 1'b0;
                wr_addr_p1 <= '0;
            end
            br_flag_p1 <= is_jump && !ds_now;
            br_addr_p1 <= (is_jump && !ds_now) ? rd_data_1[ADDR_W-1:0] : '0;
            err_p1     <= is_jump && ds_now;
        end else if (out_ready) begin
            // Transfer drained: branch/error pulses must not outlive their beat.
            vld_p1     <= 1'b0;
            br_flag_p1 <= 1'b0;
            err_p1     <= 1'b0;
        end
    end

    assign out_valid      = vld_p1;
    assign op1            = op1_p1;
    assign op2            = op2_p1;
    assign shamt          = shamt_p1;
    assign funct          = funct_p1;
    assign wr_en          = wr_en_p1;
    assign wr_addr        = wr_addr_p1;
    assign in_ds          = in_ds_p1;
    assign br_flag        = br_flag_p1 && vld_p1;
    assign br_addr        = br_addr_p1;
    assign err_jump_in_ds = err_p1;

endmodule

// File: tb/tb_id_r_pipe.sv
// Directed bench for id_r_pipe: hand-computed vectors covering decode, handshake,
// delay slot, flush and reset behaviour.
module tb_id_r_pipe;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;
    localparam int REG_AW = 5;

    logic              clk = 1'b0;
    logic              rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic [ADDR_W-1:0] pc, br_addr;
    logic [31:0]       inst;
    logic              rd_en_1, rd_en_2, wr_en, in_ds, br_flag, err_jump_in_ds;
    logic [REG_AW-1:0] rd_addr_1, rd_addr_2, wr_addr;
    logic [DATA_W-1:0] rd_data_1, rd_data_2, op1, op2;
    logic [4:0]        shamt;
    logic [5:0]        funct;

    int total = 0;
    int bad = 0;

    id_r_pipe #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .REG_AW(REG_AW)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .pc(pc), .inst(inst),
        .rd_en_1(rd_en_1), .rd_addr_1(rd_addr_1), .rd_en_2(rd_en_2), .rd_addr_2(rd_addr_2),
        .rd_data_1(rd_data_1), .rd_data_2(rd_data_2),
        .out_valid(out_valid), .out_ready(out_ready),
        .op1(op1), .op2(op2), .shamt(shamt), .funct(funct),
        .wr_en(wr_en), .wr_addr(wr_addr), .in_ds(in_ds),
        .br_flag(br_flag), .br_addr(br_addr), .err_jump_in_ds(err_jump_in_ds)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rinst(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [4:0] rd,
                                          input logic [5:0] fn);
        return {op, rs, rt, rd, 5'd0, fn};
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic [31:0] i, input logic [31:0] p,
                         input logic [31:0] d1, input logic [31:0] d2);
        in_valid  = 1'b1;
        inst      = i;
        pc        = p;
        rd_data_1 = d1;
        rd_data_2 = d2;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
        drive(rinst(6'h00, 5'd1, 5'd2, 5'd3, 6'h21), 32'h0, 32'h5, 32'h7);
        #1;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_rd_en_1", rd_en_1, 0);
        tick(); tick();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_op1", op1, 0);
        chk("rst_br_flag", br_flag, 0);
        rst = 1'b0;

        // ADDU rs=1 rt=2 rd=3
        #1;
        chk("addu_rd_en_1", rd_en_1, 1);
        chk("addu_rd_addr_1", rd_addr_1, 1);
        chk("addu_rd_addr_2", rd_addr_2, 2);
        chk("addu_in_ready", in_ready, 1);
        tick();
        chk("addu_valid", out_valid, 1);
        chk("addu_op1", op1, 5);
        chk("addu_op2", op2, 7);
        chk("addu_wr_en", wr_en, 1);
        chk("addu_wr_addr", wr_addr, 3);
        chk("addu_br", br_flag, 0);
        chk("addu_funct", funct, 6'h21);

        // JALR rs=4 rd=31 then ADDU in the delay slot
        drive(rinst(6'h00, 5'd4, 5'd0, 5'd31, 6'h09), 32'h100, 32'h400, 32'h0);
        tick();
        chk("jalr_op1", op1, 32'h108);
        chk("jalr_br", br_flag, 1);
        chk("jalr_br_addr", br_addr, 32'h400);
        chk("jalr_wr_addr", wr_addr, 31);
        chk("jalr_wr_en", wr_en, 1);
        chk("jalr_in_ds", in_ds, 0);
        drive(rinst(6'h00, 5'd1, 5'd2, 5'd5, 6'h21), 32'h108, 32'h1, 32'h2);
        tick();
        chk("ds_in_ds", in_ds, 1);
        chk("ds_br", br_flag, 0);
        chk("ds_op1", op1, 1);
        chk("ds_wr_addr", wr_addr, 5);

        // Conditional moves and rd=0
        drive(rinst(6'h00, 5'd1, 5'd2, 5'd6, 6'h0A), 32'h0, 32'h9, 32'h0);
        tick();
        chk("movz0_wr_en", wr_en, 1);
        chk("movz0_wr_addr", wr_addr, 6);
        chk("movz0_in_ds", in_ds, 0);
        drive(rinst(6'h00, 5'd1, 5'd2, 5'd6, 6'h0A), 32'h0, 32'h9, 32'h3);
        tick();
        chk("movz3_wr_en", wr_en, 0);
        chk("movz3_wr_addr", wr_addr, 0);
        drive(rinst(6'h00, 5'd1, 5'd2, 5'd6, 6'h0B), 32'h0, 32'h9, 32'h3);
        tick();
        chk("movn3_wr_en", wr_en, 1);
        drive(rinst(6'h00, 5'd1, 5'd2, 5'd0, 6'h21), 32'h0, 32'h9, 32'h3);
        tick();
        chk("rd0_wr_en", wr_en, 0);

        // Non-R (LW) passes as a bubble
        drive({6'h23, 5'd1, 5'd2, 16'h0010}, 32'h0, 32'h55, 32'h66);
        #1;
        chk("lw_rd_en_1", rd_en_1, 0);
        chk("lw_rd_addr_1", rd_addr_1, 0);
        tick();
        chk("lw_valid", out_valid, 1);
        chk("lw_op1", op1, 0);
        chk("lw_op2", op2, 0);
        chk("lw_wr_en", wr_en, 0);

        // SPECIAL2 MUL rd=7
        drive(rinst(6'h1C, 5'd1, 5'd2, 5'd7, 6'h02), 32'h0, 32'h3, 32'h4);
        #1;
        chk("mul_rd_en_2", rd_en_2, 1);
        tick();
        chk("mul_op1", op1, 3);
        chk("mul_op2", op2, 4);
        chk("mul_wr_addr", wr_addr, 7);
        chk("mul_funct", funct, 2);

        // Back-pressure: three stall cycles, then same-cycle acceptance on release
        drive(rinst(6'h00, 5'd1, 5'd2, 5'd8, 6'h21), 32'h0, 32'h11, 32'h22);
        tick();
        out_ready = 1'b0;
        drive(rinst(6'h00, 5'd1, 5'd2, 5'd9, 6'h21), 32'h0, 32'h33, 32'h44);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall_in_ready", in_ready, 0);
            tick();
            chk("stall_valid", out_valid, 1);
            chk("stall_op1", op1, 32'h11);
            chk("stall_wr_addr", wr_addr, 8);
        end
        out_ready = 1'b1;
        #1;
        chk("release_in_ready", in_ready, 1);
        tick();
        chk("release_op1", op1, 32'h33);
        chk("release_wr_addr", wr_addr, 9);

        // JR followed by JR: second is an error in the delay slot
        drive(rinst(6'h00, 5'd1, 5'd0, 5'd0, 6'h08), 32'h0, 32'h200, 32'h0);
        tick();
        chk("jr_br", br_flag, 1);
        chk("jr_br_addr", br_addr, 32'h200);
        chk("jr_wr_en", wr_en, 0);
        chk("jr_op1", op1, 0);
        drive(rinst(6'h00, 5'd1, 5'd0, 5'd0, 6'h08), 32'h0, 32'h300, 32'h0);
        tick();
        chk("jr2_br", br_flag, 0);
        chk("jr2_err", err_jump_in_ds, 1);
        chk("jr2_wr_en", wr_en, 0);
        chk("jr2_in_ds", in_ds, 1);
        drive(rinst(6'h00, 5'd1, 5'd2, 5'd3, 6'h21), 32'h0, 32'h1, 32'h2);
        tick();
        chk("after_err_in_ds", in_ds, 0);
        chk("after_err_err", err_jump_in_ds, 0);

        // Branch pulse clears when drained
        drive(rinst(6'h00, 5'd1, 5'd0, 5'd0, 6'h08), 32'h0, 32'h500, 32'h0);
        tick();
        chk("jr3_br", br_flag, 1);
        in_valid = 1'b0;
        tick();
        chk("drain_valid", out_valid, 0);
        chk("drain_br", br_flag, 0);

        // Flush with simultaneous accept while in the delay slot
        drive(rinst(6'h00, 5'd1, 5'd2, 5'd3, 6'h21), 32'h0, 32'h1, 32'h2);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_valid", out_valid, 0);
        chk("flush_br", br_flag, 0);
        drive(rinst(6'h00, 5'd1, 5'd2, 5'd4, 6'h21), 32'h0, 32'h1, 32'h2);
        tick();
        chk("post_flush_valid", out_valid, 1);
        chk("post_flush_in_ds", in_ds, 0);

        // pc+8 wraps
        drive(rinst(6'h00, 5'd4, 5'd0, 5'd31, 6'h09), 32'hFFFF_FFFC, 32'h40, 32'h0);
        tick();
        chk("wrap_op1", op1, 32'h4);
        drive(rinst(6'h00, 5'd1, 5'd2, 5'd3, 6'h21), 32'h0, 32'h1, 32'h2);
        tick();
        chk("wrap_ds_in_ds", in_ds, 1);

        // Reset during a stalled transfer
        out_ready = 1'b0;
        in_valid  = 1'b0;
        tick();
        chk("pre_rst_valid", out_valid, 1);
        rst = 1'b1;
        #1;
        chk("rst2_in_ready", in_ready, 0);
        tick();
        chk("rst2_valid", out_valid, 0);
        chk("rst2_op1", op1, 0);
        chk("rst2_wr_en", wr_en, 0);
        rst = 1'b0;
        out_ready = 1'b1;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
